// File: rtl/parsing_pkg.sv
// parsing_pkg: shared defaults and FSM encoding for the parsing BRAM loader.
// Used by parsing_bram_loader and parsing_bank_dec.
package parsing_pkg;

    localparam int DEF_NUM_BANK   = 16;
    localparam int DEF_DATA_W     = 128;
    localparam int DEF_ADDR_W     = 9;
    localparam int DEF_GAP_CYCLES = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GAP   = 2'd2,
        START = 2'd3
    } state_t;

endpackage

// File: rtl/parsing_bank_dec.sv
// parsing_bank_dec: bank index -> one-hot bank enable, gated by a write strobe.
// Purely combinational.
module parsing_bank_dec
    import parsing_pkg::*;
#(
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic [BANK_W-1:0]   bank,
    input  logic                strobe,
    output logic [NUM_BANK-1:0] oneHot
);

    // One bit set for the addressed bank, nothing when no write happens.
    always_comb begin
        oneHot = '0;
        if (strobe) begin
            oneHot = NUM_BANK'(1) << bank;
        end
    end

endmodule

// File: rtl/parsing_bram_loader.sv
// parsing_bram_loader: fills the 16-bank input BRAM array from a valid/ready
// stream, then pulses oStart. PARSING_INTERLEAVE_EN selects word-interleaved order.
module parsing_bram_loader
    import parsing_pkg::*;
#(
    parameter int NUM_BANK   = DEF_NUM_BANK,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                iLoad,
    input  logic [ADDR_W-1:0]   iDepth,
    input  logic                iValid,
    input  logic [DATA_W-1:0]   iData,
    output logic                oReady,
    output logic [NUM_BANK-1:0] o_ena,
    output logic [NUM_BANK-1:0] o_wea,
    output logic [ADDR_W-1:0]   o_addra,
    output logic [DATA_W-1:0]   o_dia,
    output logic                oStart,
    output logic                oBusy
);

    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);

    state_t state;
    state_t nextState;
    state_t afterLoad;

    logic [ADDR_W-1:0]   depthReg;
    logic [ADDR_W-1:0]   addrCnt;
    logic [BANK_W-1:0]   bankCnt;
    logic [GAP_W-1:0]    gapCnt;
    logic [NUM_BANK-1:0] decOut;
    logic                accept;
    logic                addrEnd;
    logic                bankEnd;
    logic                lastBeat;
    logic                gapDone;

    assign accept    = iValid & oReady;
    assign addrEnd   = (addrCnt == depthReg - ADDR_W'(1));
    assign bankEnd   = (bankCnt == LAST_BANK);
    assign lastBeat  = accept & addrEnd & bankEnd;
    assign gapDone   = (32'(gapCnt) == GAP_CYCLES - 1);
    // A zero-length gap skips the GAP state entirely.
    assign afterLoad = (GAP_CYCLES == 0) ? START : GAP;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: IDLE -> LOAD -> GAP -> START -> IDLE.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (iLoad) begin
                    nextState = (iDepth != '0) ? LOAD : afterLoad;
                end
            end
            LOAD: begin
                if (lastBeat) begin
                    nextState = afterLoad;
                end
            end
            GAP: begin
                if (gapDone) begin
                    nextState = START;
                end
            end
            START: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        oReady = 1'b0;
        oStart = 1'b0;
        oBusy  = 1'b1;
        unique case (state)
            IDLE:  oBusy  = 1'b0;
            LOAD:  oReady = 1'b1;
            GAP:   oReady = 1'b0;
            START: oStart = 1'b1;
            default: oBusy = 1'b0;
        endcase
    end

    // Depth latch, bank/address walk and gap counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            depthReg <= '0;
            addrCnt  <= '0;
            bankCnt  <= '0;
            gapCnt   <= '0;
        end else begin
            if (state == IDLE && iLoad) begin
                depthReg <= iDepth;
                addrCnt  <= '0;
                bankCnt  <= '0;
            end else if (accept) begin
`ifdef PARSING_INTERLEAVE_EN
                if (bankEnd) begin
                    bankCnt <= '0;
                    addrCnt <= addrCnt + ADDR_W'(1);
                end else begin
                    bankCnt <= bankCnt + BANK_W'(1);
                end
`else
                if (addrEnd) begin
                    addrCnt <= '0;
                    bankCnt <= bankCnt + BANK_W'(1);
                end else begin
                    addrCnt <= addrCnt + ADDR_W'(1);
                end
`endif
            end
            gapCnt <= (state == GAP) ? gapCnt + GAP_W'(1) : '0;
        end
    end

    parsing_bank_dec #(
        .NUM_BANK (NUM_BANK),
        .BANK_W   (BANK_W)
    ) uDec (
        .bank   (bankCnt),
        .strobe (accept),
        .oneHot (decOut)
    );

    // Registered write port: enable pulses per beat, address/data hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_ena   <= '0;
            o_addra <= '0;
            o_dia   <= '0;
        end else begin
            o_ena <= decOut;
            if (accept) begin
                o_addra <= addrCnt;
                o_dia   <= iData;
            end
        end
    end

    assign o_wea = o_ena;

endmodule

// File: tb/tb_parsing_bram_loader.sv
// tb_parsing_bram_loader: randomized directed bench for parsing_bram_loader.
// Model follows PARSING_INTERLEAVE_EN when defined.
module tb_parsing_bram_loader;

    localparam int NB  = 16;
    localparam int DW  = 128;
    localparam int AW  = 9;
    localparam int GAP = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          iLoad;
    logic [AW-1:0] iDepth;
    logic          iValid;
    logic [DW-1:0] iData;
    logic          oReady;
    logic [NB-1:0] o_ena;
    logic [NB-1:0] o_wea;
    logic [AW-1:0] o_addra;
    logic [DW-1:0] o_dia;
    logic          oStart;
    logic          oBusy;

    int nCmp  = 0;
    int nFail = 0;

    logic [AW-1:0] heldAddr;
    logic [DW-1:0] heldData;

    parsing_bram_loader dut (
        .clk     (clk),
        .rstn    (rstn),
        .iLoad   (iLoad),
        .iDepth  (iDepth),
        .iValid  (iValid),
        .iData   (iData),
        .oReady  (oReady),
        .o_ena   (o_ena),
        .o_wea   (o_wea),
        .o_addra (o_addra),
        .o_dia   (o_dia),
        .oStart  (oStart),
        .oBusy   (oBusy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Placement of beat k for a fill of depth d.
    function automatic int mBank(input int k, input int d);
`ifdef PARSING_INTERLEAVE_EN
        return k % NB;
`else
        return k / d;
`endif
    endfunction

    function automatic int mAddr(input int k, input int d);
`ifdef PARSING_INTERLEAVE_EN
        return k / NB;
`else
        return k % d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkOuts(input string ph, input logic [NB-1:0] eEna,
                           input logic eRdy, input logic eStart,
                           input logic eBusy);
        chk({ph, ".ena"},   DW'(o_ena),   DW'(eEna));
        chk({ph, ".wea"},   DW'(o_wea),   DW'(eEna));
        chk({ph, ".addr"},  DW'(o_addra), DW'(heldAddr));
        chk({ph, ".data"},  o_dia,        heldData);
        chk({ph, ".ready"}, DW'(oReady),  DW'(eRdy));
        chk({ph, ".start"}, DW'(oStart),  DW'(eStart));
        chk({ph, ".busy"},  DW'(oBusy),   DW'(eBusy));
    endtask

    // mode 0: valid always, 1: toggle 1,0,1,0, 2: random.
    // abortAt > 0 returns right after that many beats were driven.
    task automatic runFill(input int depth, input int mode, input int abortAt);
        int total;
        int k;
        int cyc;
        logic pend;
        logic v;
        logic [NB-1:0] eEna;
        total = NB * depth;
        k = 0;
        cyc = 0;
        pend = 1'b0;
        iLoad = 1'b1;
        iDepth = AW'(depth);
        iValid = 1'($urandom);
        iData = rand128();
        @(negedge clk);
        iLoad = 1'b0;
        while (k < total && !(abortAt > 0 && k >= abortAt)) begin
            eEna = pend ? (NB'(1) << mBank(k - 1, depth)) : '0;
            chkOuts("load", eEna, 1'b1, 1'b0, 1'b1);
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            iValid = v;
            iData = rand128();
            iLoad = 1'($urandom);
            iDepth = AW'($urandom);
            if (v) begin
                heldAddr = AW'(mAddr(k, depth));
                heldData = iData;
                k++;
            end
            pend = v;
            cyc++;
            @(negedge clk);
        end
        iLoad = 1'b0;
        if (k < total) begin
            iValid = 1'b0;
            return;
        end
        eEna = pend ? (NB'(1) << mBank(k - 1, depth)) : '0;
        chkOuts("gap1", eEna, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= GAP; i++) begin
            iValid = 1'($urandom);
            iData = rand128();
            @(negedge clk);
            chkOuts((i == GAP) ? "start" : "gap", '0, 1'b0, i == GAP, 1'b1);
        end
        iValid = 1'b0;
        @(negedge clk);
        chkOuts("idle", '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        iLoad = 1'b1;
        iValid = 1'b1;
        iDepth = AW'(5);
        iData = rand128();
        heldAddr = '0;
        heldData = '0;
        repeat (2) @(negedge clk);
        chkOuts("reset", '0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        iLoad = 1'b0;
        iValid = 1'b0;
        @(negedge clk);
        chkOuts("idle0", '0, 1'b0, 1'b0, 1'b0);

        runFill(128, 0, 0);
        runFill(4, 1, 0);
        runFill(0, 2, 0);
        runFill(1, 2, 0);
        runFill($urandom_range(2, 7), 2, 0);
        runFill($urandom_range(2, 7), 2, 0);

        runFill(128, 0, 300);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        heldAddr = '0;
        heldData = '0;
        chkOuts("midreset", '0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        runFill(2, 0, 0);
        runFill(3, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
